// File: rtl/store_buffer_if.sv
// rtl/store_buffer_if.sv - CPU-side and memory-side signal bundle for the store buffer
interface store_buffer_if #(
  parameter int data_length    = 32,
  parameter int address_length = 10,
  parameter int DEPTH          = 4
);
  localparam int count_width = $clog2(DEPTH) + 1;

  // CPU MEM-stage side
  logic                      cpu_read;
  logic                      cpu_write;
  logic [address_length-1:0] cpu_address;
  logic [data_length-1:0]    cpu_wdata;
  logic [data_length-1:0]    cpu_rdata;
  logic                      cpu_stall;

  // Memory-system side
  logic [address_length-1:0] mem_address;
  logic [data_length-1:0]    mem_DataIn;
  logic                      MemRead;
  logic                      MemWrite;
  logic                      mem_stall;
  logic [data_length-1:0]    mem_DataOut;

  // Occupancy status
  logic [count_width-1:0]    buf_count;
  logic                      buf_empty;

  // The store buffer itself
  modport slave (
    input  cpu_read, cpu_write, cpu_address, cpu_wdata, mem_stall, mem_DataOut,
    output cpu_rdata, cpu_stall, mem_address, mem_DataIn, MemRead, MemWrite,
    output buf_count, buf_empty
  );

  // The environment around it (CPU plus memory system)
  modport master (
    output cpu_read, cpu_write, cpu_address, cpu_wdata, mem_stall, mem_DataOut,
    input  cpu_rdata, cpu_stall, mem_address, mem_DataIn, MemRead, MemWrite,
    input  buf_count, buf_empty
  );
endinterface

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - in-order posted-store FIFO with load forwarding, drains to memory one word at a time
module store_buffer #(
  parameter int data_length    = 32,
  parameter int address_length = 10,
  parameter int DEPTH          = 4
) (
  input logic           clk,
  input logic           rst,
  store_buffer_if.slave bus
);
  localparam int ptr_width   = $clog2(DEPTH);
  localparam int count_width = ptr_width + 1;

  typedef enum logic [1:0] {IDLE, DRAIN, LOAD} state_t;

  state_t                    state, state_next;
  logic [address_length-1:0] entry_addr [DEPTH];
  logic [data_length-1:0]    entry_data [DEPTH];
  logic [ptr_width-1:0]      head, tail, idx;
  logic [count_width-1:0]    count, count_next;
  logic [address_length-1:0] load_addr;

  logic                   full;
  logic                   fwd_hit;
  logic [data_length-1:0] fwd_data;
  logic                   load_miss;
  logic                   store_req;
  logic                   push;
  logic                   pop;
  logic                   load_done;

  assign full       = (count == count_width'(DEPTH));
  assign pop        = (state == DRAIN) & ~bus.mem_stall;
  assign load_done  = (state == LOAD) & ~bus.mem_stall;
  // A simultaneous read and write is a read; the write half is dropped.
  assign store_req  = bus.cpu_write & ~bus.cpu_read;
  // A full buffer still takes a store when the head leaves on the same edge.
  assign push       = store_req & (~full | pop);
  assign load_miss  = bus.cpu_read & ~fwd_hit;
  assign count_next = count + count_width'(push) - count_width'(pop);

  // Forwarding search: walk oldest to youngest so the youngest match wins.
  // The head entry is still counted while its drain completes, so it still forwards.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + ptr_width'(k);
      if ((count_width'(k) < count) && (entry_addr[idx] == bus.cpu_address)) begin
        fwd_hit  = 1'b1;
        fwd_data = entry_data[idx];
      end
    end
  end

  // CPU response: memory data on load completion, forwarded data on a hit, stall otherwise.
  always_comb begin
    bus.cpu_rdata = '0;
    bus.cpu_stall = 1'b0;
    if (bus.cpu_read && state == LOAD) begin
      bus.cpu_stall = ~load_done;
      if (load_done) begin
        bus.cpu_rdata = bus.mem_DataOut;
      end
    end else if (bus.cpu_read) begin
      if (fwd_hit) begin
        bus.cpu_rdata = fwd_data;
      end else begin
        bus.cpu_stall = 1'b1;
      end
    end else if (store_req) begin
      bus.cpu_stall = ~push;
    end
  end

  // Next state: a pending miss wins only at a transaction boundary (IDLE or drain completion).
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (load_miss) begin
          state_next = LOAD;
        end else if (count_next != '0) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (pop) begin
          if (load_miss) begin
            state_next = LOAD;
          end else if (count_next == '0) begin
            state_next = IDLE;
          end
        end
      end
      LOAD: begin
        if (load_done) begin
          state_next = (count_next != '0) ? DRAIN : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Memory port is a pure function of state, so reset drops any request immediately.
  always_comb begin
    bus.MemWrite    = (state == DRAIN);
    bus.MemRead     = (state == LOAD);
    bus.mem_address = '0;
    bus.mem_DataIn  = '0;
    if (state == DRAIN) begin
      bus.mem_address = entry_addr[head];
      bus.mem_DataIn  = entry_data[head];
    end else if (state == LOAD) begin
      bus.mem_address = load_addr;
    end
  end

  assign bus.buf_count = count;
  assign bus.buf_empty = (count == '0);

  // Control state: FSM, FIFO pointers, occupancy and the latched miss address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      load_addr <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (push) begin
        tail <= tail + 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      if (state != LOAD && state_next == LOAD) begin
        load_addr <= bus.cpu_address;
      end
    end
  end

  // Entry storage; contents are meaningless outside the occupied window, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      entry_addr[tail] <= bus.cpu_address;
      entry_data[tail] <= bus.cpu_wdata;
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - directed and randomized checks of store_buffer against a queue model
module tb_store_buffer;
  localparam int DL    = 32;
  localparam int AL    = 10;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  store_buffer_if #(.data_length(DL), .address_length(AL), .DEPTH(DEPTH)) bus ();

  store_buffer #(.data_length(DL), .address_length(AL), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [AL-1:0] a;
    logic [DL-1:0] d;
  } ent_t;

  int total = 0;
  int bad   = 0;

  ent_t          mq[$];
  logic [AL-1:0] drained[$];
  logic [AL-1:0] exp_order[$];
  logic          hit;
  logic [DL-1:0] hit_data;
  logic          exp_stall;
  logic          wr_done;
  logic          rd_done;
  logic          pending;
  int            stall_run;
  int            r;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_store(input logic [AL-1:0] a, input logic [DL-1:0] d);
    @(posedge clk);
    #1;
    bus.cpu_read    = 1'b0;
    bus.cpu_write   = 1'b1;
    bus.cpu_address = a;
    bus.cpu_wdata   = d;
  endtask

  // Called at a negedge; records every drain completion until the buffer is idle and empty.
  task automatic drain_collect(input int budget);
    drained.delete();
    for (int i = 0; i < budget; i++) begin
      if (bus.MemWrite && !bus.mem_stall) drained.push_back(bus.mem_address);
      if (bus.buf_empty && !bus.MemWrite) break;
      @(negedge clk);
    end
    check("drain_done_empty", bus.buf_empty, 1);
  endtask

  task automatic check_order(input string tag);
    check({tag, "_size"}, drained.size(), exp_order.size());
    for (int k = 0; k < drained.size() && k < exp_order.size(); k++) begin
      check({tag, "_addr"}, drained[k], exp_order[k]);
    end
  endtask

  initial begin
    bus.cpu_read    = 1'b0;
    bus.cpu_write   = 1'b0;
    bus.cpu_address = '0;
    bus.cpu_wdata   = '0;
    bus.mem_stall   = 1'b0;
    bus.mem_DataOut = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_count", bus.buf_count, 0);
    check("reset_empty", bus.buf_empty, 1);
    check("reset_memwrite", bus.MemWrite, 0);
    check("reset_memread", bus.MemRead, 0);
    check("reset_stall", bus.cpu_stall, 0);
    rst = 1'b0;

    // Reset while a drain is held off by mem_stall
    bus.mem_stall = 1'b1;
    drive_store(10'h055, 32'h0000_1234);
    @(posedge clk);
    #1;
    bus.cpu_write = 1'b0;
    @(negedge clk);
    check("t1_memwrite_before", bus.MemWrite, 1);
    #2;
    rst = 1'b1;
    #1;
    check("t1_memwrite_async", bus.MemWrite, 0);
    check("t1_count", bus.buf_count, 0);
    check("t1_empty", bus.buf_empty, 1);
    check("t1_stall", bus.cpu_stall, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.mem_stall = 1'b0;

    // Single store, next-cycle MemWrite
    drive_store(10'h3A4, 32'hDEADBEEF);
    @(negedge clk);
    check("t2_stall", bus.cpu_stall, 0);
    @(posedge clk);
    #1;
    bus.cpu_write = 1'b0;
    @(negedge clk);
    check("t2_memwrite", bus.MemWrite, 1);
    check("t2_addr", bus.mem_address, 10'h3A4);
    check("t2_data", bus.mem_DataIn, 32'hDEADBEEF);
    check("t2_count", bus.buf_count, 1);
    @(negedge clk);
    check("t2_empty", bus.buf_empty, 1);
    check("t2_memwrite_off", bus.MemWrite, 0);

    // Fill to full, fifth store waits, then enters on the drain completion edge
    bus.mem_stall = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive_store(AL'(i), 32'hA000_0000 + i);
      @(negedge clk);
      check("t3_accept_stall", bus.cpu_stall, 0);
    end
    drive_store(10'h005, 32'hA000_0005);
    @(negedge clk);
    check("t3_full_count", bus.buf_count, 4);
    check("t3_full_stall", bus.cpu_stall, 1);
    @(negedge clk);
    check("t3_full_stall_hold", bus.cpu_stall, 1);
    @(posedge clk);
    #1;
    bus.mem_stall = 1'b0;
    @(negedge clk);
    check("t6_accept_on_pop", bus.cpu_stall, 0);
    check("t3_first_drain", bus.mem_address, 10'h001);
    @(posedge clk);
    #1;
    bus.cpu_write = 1'b0;
    @(negedge clk);
    check("t6_count_stays", bus.buf_count, 4);
    drain_collect(40);
    exp_order = '{10'h002, 10'h003, 10'h004, 10'h005};
    check_order("t3_order");

    // Same-address stores, youngest forwards
    bus.mem_stall = 1'b1;
    drive_store(10'h010, 32'h1111_1111);
    drive_store(10'h010, 32'h2222_2222);
    @(posedge clk);
    #1;
    bus.cpu_write   = 1'b0;
    bus.cpu_read    = 1'b1;
    bus.cpu_address = 10'h010;
    @(negedge clk);
    check("t4_rdata", bus.cpu_rdata, 32'h2222_2222);
    check("t4_stall", bus.cpu_stall, 0);
    check("t4_memread", bus.MemRead, 0);
    check("t4_count", bus.buf_count, 2);
    @(posedge clk);
    #1;
    bus.cpu_read  = 1'b0;
    bus.mem_stall = 1'b0;
    @(negedge clk);
    check("t4_memread_later", bus.MemRead, 0);
    drain_collect(40);
    exp_order = '{10'h010, 10'h010};
    check_order("t4_order");

    // Load miss waits for the in-flight drain, then precedes the rest
    bus.mem_stall = 1'b1;
    drive_store(10'h100, 32'h0000_0100);
    drive_store(10'h101, 32'h0000_0101);
    @(posedge clk);
    #1;
    bus.cpu_write   = 1'b0;
    bus.cpu_read    = 1'b1;
    bus.cpu_address = 10'h2F0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_stall_wait", bus.cpu_stall, 1);
      check("t5_no_read_yet", bus.MemRead, 0);
      check("t5_drain_held", bus.MemWrite, 1);
    end
    @(posedge clk);
    #1;
    bus.mem_stall   = 1'b0;
    bus.mem_DataOut = 32'hCAFEF00D;
    @(negedge clk);
    check("t5_drain_addr", bus.mem_address, 10'h100);
    check("t5_stall_drain", bus.cpu_stall, 1);
    @(negedge clk);
    check("t5_memread", bus.MemRead, 1);
    check("t5_memwrite_off", bus.MemWrite, 0);
    check("t5_read_addr", bus.mem_address, 10'h2F0);
    check("t5_rdata", bus.cpu_rdata, 32'hCAFEF00D);
    check("t5_stall_done", bus.cpu_stall, 0);
    @(posedge clk);
    #1;
    bus.cpu_read    = 1'b0;
    bus.mem_DataOut = '0;
    @(negedge clk);
    drain_collect(40);
    exp_order = '{10'h101};
    check_order("t5_order");

    // Randomized traffic against the queue model
    mq.delete();
    pending   = 1'b0;
    stall_run = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk);
      #1;
      if (!pending) begin
        r = $urandom_range(0, 5);
        bus.cpu_read    = (r == 1) || (r == 2) || (r == 5);
        bus.cpu_write   = (r == 3) || (r == 4) || (r == 5);
        bus.cpu_address = AL'($urandom_range(0, 11));
        bus.cpu_wdata   = $urandom;
      end
      bus.mem_stall   = ($urandom_range(0, 2) == 0);
      bus.mem_DataOut = $urandom;
      @(negedge clk);

      check("r_both_req", bus.MemRead & bus.MemWrite, 0);
      check("r_count", bus.buf_count, mq.size());
      check("r_empty", bus.buf_empty, mq.size() == 0);
      check("r_read_needs_load", bus.MemRead & ~bus.cpu_read, 0);
      wr_done = bus.MemWrite && !bus.mem_stall;
      rd_done = bus.MemRead && !bus.mem_stall;
      if (bus.MemWrite) begin
        check("r_drain_nonempty", mq.size() != 0, 1);
        if (mq.size() != 0) begin
          check("r_drain_addr", bus.mem_address, mq[0].a);
          check("r_drain_data", bus.mem_DataIn, mq[0].d);
        end
      end

      hit      = 1'b0;
      hit_data = '0;
      foreach (mq[i]) begin
        if (mq[i].a == bus.cpu_address) begin
          hit      = 1'b1;
          hit_data = mq[i].d;
        end
      end

      exp_stall = 1'b0;
      if (bus.cpu_read) begin
        if (rd_done) begin
          check("r_load_addr", bus.mem_address, bus.cpu_address);
          check("r_load_rdata", bus.cpu_rdata, bus.mem_DataOut);
        end else if (bus.MemRead) begin
          exp_stall = 1'b1;
          check("r_load_addr_wait", bus.mem_address, bus.cpu_address);
        end else if (hit) begin
          check("r_fwd_rdata", bus.cpu_rdata, hit_data);
        end else begin
          exp_stall = 1'b1;
          check("r_miss_rdata", bus.cpu_rdata, 0);
        end
      end else begin
        check("r_idle_rdata", bus.cpu_rdata, 0);
        if (bus.cpu_write) exp_stall = !((mq.size() < DEPTH) || wr_done);
      end
      check("r_stall", bus.cpu_stall, exp_stall);

      if (wr_done && mq.size() != 0) void'(mq.pop_front());
      if (bus.cpu_write && !bus.cpu_read && !exp_stall) mq.push_back({bus.cpu_address, bus.cpu_wdata});

      pending   = exp_stall;
      stall_run = exp_stall ? stall_run + 1 : 0;
      if (stall_run > 200) begin
        check("r_stall_bound", stall_run, 0);
        pending   = 1'b0;
        stall_run = 0;
      end
    end

    @(posedge clk);
    #1;
    bus.cpu_read  = 1'b0;
    bus.cpu_write = 1'b0;
    bus.mem_stall = 1'b0;
    @(negedge clk);
    drain_collect(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
